// File: rtl/block_data_memory.sv
// Block-granular data memory behind a cache: 64 x 32-bit blocks with a fixed,
// parameterised access latency and a busywait handshake to the cache controller.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is one of read/write held high in IDLE; busywait
    // rises combinationally with it, stays high while the access is in flight,
    // and drops in the single DONE cycle, where readdata is valid and the
    // requester must release read/write before the next edge.

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("block_data_memory: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_op_write;
    logic [5:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_readdata;
    logic [31:0] r_mem [64];

    logic        w_req_valid;

    // Both strobes high is an illegal request and is treated as no request.
    assign w_req_valid = read ^ write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_op_write <= 1'b0;
            r_addr     <= 6'd0;
            r_wdata    <= 32'd0;
            r_readdata <= 32'd0;
            for (int i = 0; i < 64; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_op_write <= write;
                        r_addr     <= address;
                        r_wdata    <= writedata;
                        r_count    <= COUNT_LOAD;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        // Only latched request fields are used past acceptance.
                        if (r_op_write) begin
                            r_mem[r_addr] <= r_wdata;
                        end else begin
                            r_readdata <= r_mem[r_addr];
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busywait = 1'b0;
        case (r_state)
            IDLE:    busywait = w_req_valid;
            ACCESS:  busywait = 1'b1;
            DONE:    busywait = 1'b0;
            default: busywait = 1'b0;
        endcase
    end

    assign readdata    = r_readdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: a driver issues requests and pushes the
// expected readdata into a queue; a monitor pops and compares at each DONE cycle.
module tb_block_data_memory;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic        clock;
    logic        reset;
    logic        read, write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic [1:0]  dbg_state;

    logic        read1, write1;
    logic [5:0]  address1;
    logic [31:0] writedata1;
    logic [31:0] readdata1;
    logic        busywait1;
    logic [1:0]  dbg_state1;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] model[64];
    logic [31:0] last_rd;

    block_data_memory #(.LATENCY(5)) u_dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .o_dbg_state(dbg_state)
    );

    block_data_memory #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .read(read1), .write(write1),
        .address(address1), .writedata(writedata1), .readdata(readdata1),
        .busywait(busywait1), .o_dbg_state(dbg_state1)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every DONE cycle of the LATENCY=5 instance consumes one expectation.
    always @(negedge clock) begin
        if (dbg_state == ST_DONE) begin
            check("done_busywait", 32'(busywait), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("readdata", readdata, exp_q.pop_front());
            end
        end
    end

    // Driver: one request on the LATENCY=5 instance. chg > 0 rewrites the
    // address/writedata inputs after that many ACCESS cycles.
    task automatic issue(input logic is_wr, input logic [5:0] a, input logic [31:0] d,
                         input int chg, input logic [5:0] a2, input logic [31:0] d2);
        int cnt;
        @(posedge clock); #1;
        read = ~is_wr; write = is_wr; address = a; writedata = d;
        if (is_wr) model[a] = d;
        else last_rd = model[a];
        exp_q.push_back(last_rd);
        @(negedge clock);
        check("idle_busywait", 32'(busywait), 32'd1);
        @(posedge clock); #1;
        // busywait cycles counted from the acceptance edge to the completion edge
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!busywait) break;
            cnt++;
            if (chg > 0 && cnt == chg) begin
                address = a2; writedata = d2;
            end
        end
        read = 1'b0; write = 1'b0;
        check("busy_cycles", 32'(cnt), 32'd5);
    endtask

    task automatic issue1(input logic is_wr, input logic [5:0] a, input logic [31:0] d,
                          output int cnt);
        @(posedge clock); #1;
        read1 = ~is_wr; write1 = is_wr; address1 = a; writedata1 = d;
        @(posedge clock); #1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busywait1) break;
            cnt++;
        end
        read1 = 1'b0; write1 = 1'b0;
    endtask

    initial begin
        int cnt1;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; read = 0; write = 0; address = 0; writedata = 0;
        read1 = 0; write1 = 0; address1 = 0; writedata1 = 0;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        last_rd = 32'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_readdata", readdata, 32'd0);

        // Read of a cleared block, then write/read round trip
        issue(1'b0, 6'h05, 32'h0, 0, 6'h0, 32'h0);
        issue(1'b1, 6'h2A, 32'hDEADBEEF, 0, 6'h0, 32'h0);
        issue(1'b0, 6'h2A, 32'h0, 0, 6'h0, 32'h0);
        issue(1'b1, 6'h07, 32'h01020304, 0, 6'h0, 32'h0);

        // Both strobes high is ignored
        @(posedge clock); #1;
        read = 1'b1; write = 1'b1; address = 6'h2A; writedata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("both_busywait", 32'(busywait), 32'd0);
            check("both_state", 32'(dbg_state), 32'(ST_IDLE));
            check("both_readdata", readdata, last_rd);
        end
        read = 1'b0; write = 1'b0;
        issue(1'b0, 6'h2A, 32'h0, 0, 6'h0, 32'h0);

        // Input changes during ACCESS must not leak into the access
        issue(1'b1, 6'h3F, 32'h12345678, 2, 6'h00, 32'hFFFFFFFF);
        issue(1'b0, 6'h3F, 32'h0, 0, 6'h0, 32'h0);
        issue(1'b0, 6'h00, 32'h0, 0, 6'h0, 32'h0);
        issue(1'b0, 6'h07, 32'h0, 0, 6'h0, 32'h0);

        // Reset on the 3rd ACCESS edge discards the in-flight write
        @(posedge clock); #1;
        write = 1'b1; address = 6'h10; writedata = 32'hCAFEF00D;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1; write = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        last_rd = 32'd0;
        @(negedge clock);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_busywait", 32'(busywait), 32'd0);
        check("abort_readdata", readdata, 32'd0);
        issue(1'b0, 6'h10, 32'h0, 0, 6'h0, 32'h0);
        issue(1'b0, 6'h2A, 32'h0, 0, 6'h0, 32'h0);

        // LATENCY=1 instance
        issue1(1'b1, 6'h01, 32'hA5A5A5A5, cnt1);
        check("l1_wr_busy", 32'(cnt1), 32'd1);
        check("l1_wr_readdata", readdata1, 32'd0);
        issue1(1'b0, 6'h01, 32'h0, cnt1);
        check("l1_rd_busy", 32'(cnt1), 32'd1);
        check("l1_rd_readdata", readdata1, 32'hA5A5A5A5);

        repeat (3) @(posedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
